// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
//   uart_state_e  : transmitter FSM state encoding
//   PAR_*         : parity-mode selector values for PARITY_MODE
//   *_MIN / *_MAX : legal ranges for the uart_tx_param parameters
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 2;
    localparam int OVERSAMPLE_MAX = 256;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_tx_param_baud_tick.sv
// Bit-time counter for the UART transmitter.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   restart : synchronous clear; holds the count at 0 while asserted
//   tick    : high on the last clk cycle of each OVERSAMPLE-cycle bit period
module uart_baud_tick #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits, OVERSAMPLE clk cycles per bit.
// Optional feature: define UART_TX_PARITY_EN to build the parity stage; without
// it PARITY_MODE has no functional effect and frames are start/data/stop only.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   data_in : frame payload, latched on the accept edge (valid && ready)
//   valid   : send request
//   ready   : high in IDLE only
//   busy    : inverse of ready
//   done    : one-cycle pulse on the last cycle of the stop period
//   tx      : registered serial line, idles high
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | line high, waiting for valid
// ST_START  | start bit (tx = 0)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit(s) (tx = 1), done on the final cycle
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS=%0d out of range", DATA_BITS);
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
        $error("uart_tx_param: OVERSAMPLE=%0d out of range", OVERSAMPLE);
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS=%0d out of range", STOP_BITS);
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE=%0d illegal", PARITY_MODE);
    end

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 done_c;
    logic                 tick;
    logic                 accept;

    assign ready  = (state_q == ST_IDLE);
    assign busy   = ~ready;
    assign accept = valid && ready;
    assign tx     = tx_q;
    assign done   = done_c;

    // Counter is held at zero in IDLE so the start bit gets a full bit time
    // beginning on the cycle after acceptance.
    uart_baud_tick #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(state_q == ST_IDLE),
        .tick   (tick)
    );

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY_MODE != PAR_NONE);
    logic par_q;

    // Parity is fixed at acceptance because the payload is shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= (^data_in) ^ (PARITY_MODE == PAR_ODD);
        end
    end
`endif

    // tx is computed from the next state so the line changes on the same edge
    // as the state, keeping tx a clean register output.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        done_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = ST_START;
                    shreg_d    = data_in;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        if (PAR_ON) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param. Four instances:
//   0: default 8N1, OVERSAMPLE 16
//   1: DATA_BITS 7, STOP_BITS 2, OVERSAMPLE 4
//   2: PARITY_MODE 1 (even), otherwise default
//   3: PARITY_MODE 2 (odd), OVERSAMPLE 4
// Expected frames (line level per bit, index 0 = start bit) are hand-written.
module tb_uart_tx_param;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] valid_s = 4'b0;
    logic [3:0] ready_s, busy_s, done_s, tx_s;
    logic [7:0] dat_a = '0, dat_c = '0, dat_d = '0;
    logic [6:0] dat_b = '0;

    int checks = 0;
    int errors = 0;

    exp_t q0[$], q1[$], q2[$], q3[$];

    bit          in_fr[4];
    int          cnt[4];
    logic [15:0] fbits[4];
    bit          stable[4];
    int          gap[4];
    int          last_gap[4];
    int          done_tot[4];

    always #5 clk = ~clk;

    uart_tx_param u_a (
        .clk(clk), .rst_n(rst_n), .data_in(dat_a), .valid(valid_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]), .tx(tx_s[0])
    );
    uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(2), .PARITY_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(dat_b), .valid(valid_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]), .tx(tx_s[1])
    );
    uart_tx_param #(.PARITY_MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(dat_c), .valid(valid_s[2]),
        .ready(ready_s[2]), .busy(busy_s[2]), .done(done_s[2]), .tx(tx_s[2])
    );
    uart_tx_param #(.OVERSAMPLE(4), .PARITY_MODE(2)) u_d (
        .clk(clk), .rst_n(rst_n), .data_in(dat_d), .valid(valid_s[3]),
        .ready(ready_s[3]), .busy(busy_s[3]), .done(done_s[3]), .tx(tx_s[3])
    );

    function automatic int os_of(input int i);
        case (i)
            1, 3:    return 4;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [15:0] b, input int nb, input int len);
        exp_t e;
        e.bits = b; e.nbits = nb; e.len = len;
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = 1'b1;
        e.bits = '0; e.nbits = 0; e.len = 0;
        case (i)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            2: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
            default: if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int q_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // Monitor: rebuilds each frame from tx, checks every bit period is constant,
    // and compares the frame against the scoreboard when done pulses.
    initial begin
        for (int i = 0; i < 4; i++) begin
            in_fr[i] = 0; cnt[i] = 0; fbits[i] = '0; stable[i] = 1;
            gap[i] = 0; last_gap[i] = 0; done_tot[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) begin
                    in_fr[i] = 0;
                    gap[i] = 0;
                end else begin
                    if (!in_fr[i]) begin
                        if (tx_s[i] == 1'b0) begin
                            in_fr[i] = 1; cnt[i] = 0; fbits[i] = '0; stable[i] = 1;
                            last_gap[i] = gap[i]; gap[i] = 0;
                        end else begin
                            gap[i]++;
                            if (done_s[i]) begin
                                checks++; errors++;
                                $display("FAIL done_outside_frame[%0d]: got done=1 expected 0", i);
                            end
                        end
                    end
                    if (in_fr[i]) begin
                        int bn;
                        bn = cnt[i] / os_of(i);
                        if (bn < 16) begin
                            if (cnt[i] % os_of(i) == 0) fbits[i][bn] = tx_s[i];
                            else if (tx_s[i] !== fbits[i][bn]) stable[i] = 0;
                        end
                        cnt[i]++;
                        if (done_s[i]) begin
                            exp_t e;
                            bit ok;
                            logic [15:0] m;
                            done_tot[i]++;
                            pop_exp(i, e, ok);
                            if (!ok) begin
                                checks++; errors++;
                                $display("FAIL unexpected_frame[%0d]: got frame %0h expected none", i, fbits[i]);
                            end else begin
                                m = (16'h1 << e.nbits) - 16'h1;
                                chk($sformatf("frame_len[%0d]", i), cnt[i], e.len);
                                chk($sformatf("frame_bits[%0d]", i), fbits[i] & m, e.bits);
                                chk($sformatf("bit_stable[%0d]", i), stable[i], 1);
                            end
                            in_fr[i] = 0;
                            gap[i] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic set_data(input int i, input logic [7:0] d);
        case (i)
            0: dat_a = d;
            1: dat_b = d[6:0];
            2: dat_c = d;
            default: dat_d = d;
        endcase
    endtask

    // Called on a negedge; returns 1 ns after the accept edge.
    task automatic send(input int i, input logic [7:0] d, input logic [15:0] b,
                        input int nb, input int len, input bit push);
        int k;
        for (k = 0; k < 1000; k++) begin
            if (ready_s[i]) break;
            @(negedge clk);
        end
        if (k == 1000) begin
            checks++; errors++;
            $display("FAIL ready_timeout[%0d]: got ready=0 expected 1", i);
        end
        set_data(i, d);
        if (push) push_exp(i, b, nb, len);
        valid_s[i] = 1'b1;
        @(posedge clk);
        #1;
        valid_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done_s[i]) break;
        end
        if (k == 2000) begin
            checks++; errors++;
            $display("FAIL done_timeout[%0d]: got done=0 expected 1", i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;

        #12;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_tx[%0d]", i), tx_s[i], 1);
            chk($sformatf("reset_ready[%0d]", i), ready_s[i], 1);
            chk($sformatf("reset_busy[%0d]", i), busy_s[i], 0);
            chk($sformatf("reset_done[%0d]", i), done_s[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 on 8N1: start, 1,0,1,0,0,1,0,1, stop
        send(0, 8'hA5, 16'b11_0100_1010, 10, 160, 1);
        chk("accept_ready_low", ready_s[0], 0);
        chk("accept_busy_high", busy_s[0], 1);
        chk("start_bit_tx", tx_s[0], 0);
        wait_done(0);
        chk("done_tx_high", tx_s[0], 1);
        @(negedge clk);
        chk("ready_after_done", ready_s[0], 1);
        chk("busy_after_done", busy_s[0], 0);
        chk("done_single_cycle", done_s[0], 0);

        // Back-to-back with valid held: 0x01 then 0x80
        repeat (3) @(negedge clk);
        d0 = done_tot[0];
        push_exp(0, 16'b10_0000_0010, 10, 160);
        push_exp(0, 16'b11_0000_0000, 10, 160);
        dat_a = 8'h01;
        valid_s[0] = 1'b1;
        @(posedge clk);
        #1;
        dat_a = 8'h80;
        @(negedge clk);
        for (k = 0; k < 400; k++) begin
            if (ready_s[0]) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        valid_s[0] = 1'b0;
        wait_done(0);
        repeat (20) @(negedge clk);
        chk("b2b_done_count", done_tot[0] - d0, 2);
        chk("b2b_idle_gap", last_gap[0], 1);

        // Valid toggled with 0xFF during a 0x00 frame is ignored
        d0 = done_tot[0];
        send(0, 8'h00, 16'b10_0000_0000, 10, 160, 1);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            dat_a = 8'hFF;
            valid_s[0] = ~valid_s[0];
        end
        valid_s[0] = 1'b0;
        wait_done(0);
        repeat (40) @(negedge clk);
        chk("toggle_done_count", done_tot[0] - d0, 1);
        chk("toggle_no_extra_frame", in_fr[0], 0);

        // Reset mid-frame, then accept on the first edge after release
        send(0, 8'h3C, 16'h0, 10, 160, 0);
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx_s[0], 1);
        chk("midreset_ready", ready_s[0], 1);
        chk("midreset_busy", busy_s[0], 0);
        chk("midreset_done", done_s[0], 0);
        dat_a = 8'h5A;
        valid_s[0] = 1'b1;
        push_exp(0, 16'b10_1011_0100, 10, 160);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        valid_s[0] = 1'b0;
        chk("accept_first_edge", busy_s[0], 1);
        wait_done(0);
        @(negedge clk);
        chk("ready_after_reset_frame", ready_s[0], 1);

        // 7 data bits, 2 stop bits, 4 cycles per bit
        send(1, 8'h55, 16'b11_1010_1010, 10, 40, 1);
        wait_done(1);
        send(1, 8'h0F, 16'b11_0001_1110, 10, 40, 1);
        wait_done(1);

`ifdef UART_TX_PARITY_EN
        // even parity of 0x07 = 1; odd parity of 0x00 = 1
        send(2, 8'h07, 16'b110_0000_1110, 11, 176, 1);
        wait_done(2);
        send(3, 8'h00, 16'b110_0000_0000, 11, 44, 1);
        wait_done(3);
`else
        send(2, 8'h07, 16'b10_0000_1110, 10, 160, 1);
        wait_done(2);
        send(3, 8'h00, 16'b10_0000_0000, 10, 40, 1);
        wait_done(3);
`endif

        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("scoreboard_empty[%0d]", i), q_size(i), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 Parameter OVERSAMPLE, default 16: clk cycles per bit, legal range 2..256.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-005 Parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-006 Port clk, input, 1: UART clock; all logic rises on posedge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port data_in, input, DATA_BITS: frame payload, sampled only at acceptance.
REQ-009 Port valid, input, 1: request to send data_in.
REQ-010 Port ready, output, 1: high when a new frame can be accepted.
REQ-011 Port busy, output, 1: high while a frame is on the line.
REQ-012 Port done, output, 1: one-cycle pulse marking frame end.
REQ-013 Port tx, output, 1: serial line; idle level is 1.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Acceptance SHALL occur on the clk edge where valid && ready; data_in is latched on that edge.
REQ-016 ready SHALL be 1 only in IDLE; busy SHALL be the inverse of ready.
REQ-017 START SHALL begin on the cycle after acceptance; tx is registered and drives 0 for OVERSAMPLE cycles.
REQ-018 DATA SHALL send the latched bits LSB first, each for exactly OVERSAMPLE cycles.
REQ-019 PARITY SHALL be entered only when parity is compiled in and PARITY_MODE != 0; it sends XOR of the data bits (even) or its inverse (odd) for OVERSAMPLE cycles.
REQ-020 STOP SHALL drive tx=1 for STOP_BITS*OVERSAMPLE cycles, then return to IDLE.
REQ-021 done SHALL pulse high on the last cycle of STOP and only there.
REQ-022 tx SHALL be held at 1 in IDLE.
REQ-023 Back-to-back frames with valid held high SHALL be separated by exactly one IDLE cycle.
REQ-024 valid asserted while busy SHALL be ignored; there is no queuing, and changes to data_in after acceptance have no effect.
REQ-025 The bit-time counter SHALL be $clog2(OVERSAMPLE) bits wide and wrap to 0 at OVERSAMPLE-1; the bit index SHALL be $clog2(DATA_BITS) bits wide.
REQ-026 An illegal parameter value SHALL cause an elaboration-time error.

Reset
REQ-027 On rst_n low, the block SHALL immediately set tx=1, ready=1, busy=0, done=0, state IDLE, and clear all counters, including mid-frame.
REQ-028 The first acceptance SHALL be possible on the first clk edge after rst_n deasserts.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, the PARITY state and the PARITY_MODE parameter SHALL be functional.
REQ-030 Without UART_TX_PARITY_EN, no parity logic SHALL be built, PARITY_MODE SHALL be ignored, and frames SHALL be start, data, stop only.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum typedef, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the legal parameter-range constants.
REQ-032 The bit-time counter SHALL be a sub-module, uart_baud_tick, with inputs clk, rst_n and restart, and output tick that pulses every OVERSAMPLE cycles.

Verification
REQ-033 Default configuration (8N1, OVERSAMPLE=16): accept 0xA5 -> tx reads 0,1,0,1,0,0,1,0,1,1 with 16 cycles per bit, done pulses 160 cycles after the accept edge, and ready returns the next cycle.
REQ-034 With UART_TX_PARITY_EN and PARITY_MODE=1, send 0x07 -> parity bit is 1 and the frame lasts 176 cycles; with PARITY_MODE=2, send 0x00 -> parity bit is 1.
REQ-035 DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=4: send 0x55 -> frame lasts 40 cycles and the stop level lasts 8 cycles.
REQ-036 valid held high with data 0x01 then 0x80 -> two frames separated by one idle cycle of tx=1, with exactly two done pulses.
REQ-037 Toggle valid with 0xFF during a 0x00 frame -> the frame is unaltered and no extra frame is sent.
REQ-038 Assert rst_n low at cycle 50 of a frame -> tx=1 and ready=1 without waiting for clk, and the next accept starts a clean frame.
